// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron evaluation datapath.
// Words are signed two's complement fixed point (Q16.16 at the defaults).
package neuron_pkg;

    localparam int WORD_W    = 32;
    localparam int FRAC_BITS = 16;

    typedef logic signed [WORD_W-1:0] word_t;

    localparam word_t WORD_MAX = {1'b0, {(WORD_W-1){1'b1}}};
    localparam word_t WORD_MIN = {1'b1, {(WORD_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } fp_state_t;

endpackage

// File: rtl/mac_sat.sv
// Combinational saturating fixed-point multiply-accumulate: acc + sat(x*w >>> FRAC).
// sat reports a clamp in either the scaled product or the accumulation.
module mac_sat
    import neuron_pkg::*;
#(
    parameter int W    = WORD_W,
    parameter int FRAC = FRAC_BITS
) (
    input  logic signed [W-1:0] acc,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] w,
    output logic signed [W-1:0] acc_next,
    output logic                sat
);

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic signed [2*W-1:0] prod_s;
    logic signed [2*W-1:0] shifted_s;
    logic signed [W-1:0]   prod_sat_s;
    logic                  prod_clamp_s;
    logic signed [W:0]     sum_s;
    logic                  add_clamp_s;

    // Scale the full-width product, then clamp product and sum independently
    always_comb begin
        prod_s    = $signed({{W{x[W-1]}}, x}) * $signed({{W{w[W-1]}}, w});
        shifted_s = prod_s >>> FRAC;

        // The product fits in W bits only if its top W+1 bits are all sign copies
        if (shifted_s[2*W-1:W-1] == {(W+1){shifted_s[2*W-1]}}) begin
            prod_sat_s   = shifted_s[W-1:0];
            prod_clamp_s = 1'b0;
        end else begin
            prod_sat_s   = shifted_s[2*W-1] ? MIN_V : MAX_V;
            prod_clamp_s = 1'b1;
        end

        sum_s = {acc[W-1], acc} + {prod_sat_s[W-1], prod_sat_s};

        if (sum_s[W] != sum_s[W-1]) begin
            acc_next    = sum_s[W] ? MIN_V : MAX_V;
            add_clamp_s = 1'b1;
        end else begin
            acc_next    = sum_s[W-1:0];
            add_clamp_s = 1'b0;
        end

        sat = prod_clamp_s | add_clamp_s;
    end

endmodule

// File: rtl/forward_propagator.sv
// Forward-pass evaluator for one neuron: serial saturating MAC over N_IN inputs,
// threshold compare, and result return over a valid/ready handshake.
module forward_propagator
    import neuron_pkg::*;
#(
    parameter int N_IN = 32,
    parameter int W    = WORD_W,
    parameter int FRAC = FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fp_start,
    output logic                  fp_ready,
    input  logic [N_IN*W-1:0]     fp_x,
    input  logic [(N_IN+1)*W-1:0] fp_w,
    output logic                  fp_out_valid,
    input  logic                  fp_out_ready,
    output logic [W-1:0]          fp_sum,
    output logic                  fp_fire,
    output logic [W-1:0]          fp_tm,
    output logic                  fp_sat
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    fp_state_t              state_r;
    logic [IDX_W-1:0]       idx_r;
    logic signed [W-1:0]    x_r [N_IN];
    logic signed [W-1:0]    w_r [N_IN];
    logic signed [W-1:0]    thr_r;
    logic signed [W-1:0]    acc_r;
    logic                   acc_sat_r;
    logic [W-1:0]           cnt_r;
    logic                   ready_r;
    logic                   valid_r;
    logic signed [W-1:0]    sum_r;
    logic                   fire_r;
    logic [W-1:0]           tm_r;
    logic                   sat_r;

    logic signed [W-1:0]    mac_acc_s;
    logic                   mac_sat_s;

    mac_sat #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mac (
        .acc      (acc_r),
        .x        (x_r[idx_r]),
        .w        (w_r[idx_r]),
        .acc_next (mac_acc_s),
        .sat      (mac_sat_s)
    );

    // FSM, operand capture, accumulation, cycle counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_W{1'b0}};
            thr_r     <= {W{1'b0}};
            acc_r     <= {W{1'b0}};
            acc_sat_r <= 1'b0;
            cnt_r     <= {W{1'b0}};
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            sum_r     <= {W{1'b0}};
            fire_r    <= 1'b0;
            tm_r      <= {W{1'b0}};
            sat_r     <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                x_r[i] <= {W{1'b0}};
                w_r[i] <= {W{1'b0}};
            end
        end else begin
            cnt_r <= cnt_r + W'(1);
            case (state_r)
                IDLE: begin
                    if (fp_start) begin
                        for (int i = 0; i < N_IN; i++) begin
                            x_r[i] <= fp_x[i*W +: W];
                            w_r[i] <= fp_w[i*W +: W];
                        end
                        thr_r     <= fp_w[N_IN*W +: W];
                        acc_r     <= {W{1'b0}};
                        acc_sat_r <= 1'b0;
                        idx_r     <= {IDX_W{1'b0}};
                        ready_r   <= 1'b0;
                        state_r   <= ACCUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    acc_r     <= mac_acc_s;
                    acc_sat_r <= acc_sat_r | mac_sat_s;
                    if (idx_r == IDX_LAST) begin
                        state_r <= COMPARE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                COMPARE: begin
                    sum_r   <= acc_r;
                    fire_r  <= (acc_r >= thr_r);
                    tm_r    <= cnt_r;
                    sat_r   <= acc_sat_r;
                    valid_r <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    // Result registers hold past the handshake; only valid drops
                    if (fp_out_ready) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign fp_ready     = ready_r;
    assign fp_out_valid = valid_r;
    assign fp_sum       = sum_r;
    assign fp_fire      = fire_r;
    assign fp_tm        = tm_r;
    assign fp_sat       = sat_r;

endmodule

// File: tb/tb_forward_propagator.sv
// Directed and randomized checks of forward_propagator against an arithmetic
// reference model of the saturating Q16.16 weighted sum and threshold compare.
module tb_forward_propagator;

    localparam int N_IN = 32;
    localparam int W    = 32;
    localparam int FRAC = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  fp_start;
    logic                  fp_ready;
    logic [N_IN*W-1:0]     fp_x;
    logic [(N_IN+1)*W-1:0] fp_w;
    logic                  fp_out_valid;
    logic                  fp_out_ready;
    logic [W-1:0]          fp_sum;
    logic                  fp_fire;
    logic [W-1:0]          fp_tm;
    logic                  fp_sat;

    int          checks = 0;
    int          errors = 0;
    int          x_v [N_IN];
    int          w_v [N_IN];
    int          thr;
    logic [31:0] model_cnt = 32'd0;

    forward_propagator #(.N_IN(N_IN), .W(W), .FRAC(FRAC)) dut (
        .clk          (clk),
        .rst          (rst),
        .fp_start     (fp_start),
        .fp_ready     (fp_ready),
        .fp_x         (fp_x),
        .fp_w         (fp_w),
        .fp_out_valid (fp_out_valid),
        .fp_out_ready (fp_out_ready),
        .fp_sum       (fp_sum),
        .fp_fire      (fp_fire),
        .fp_tm        (fp_tm),
        .fp_sat       (fp_sat)
    );

    always #5 clk = ~clk;

    // Free-running cycle count as seen by the neuron: cleared by reset, +1 per edge
    always @(posedge clk) model_cnt <= rst ? 32'd0 : model_cnt + 32'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-precision products, floor-scaled, clamped, summed with clamping
    task automatic model(output logic [31:0] s, output logic st, output logic fire);
        longint acc;
        longint p;
        acc = 64'sd0;
        st  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            p = (longint'(x_v[i]) * longint'(w_v[i])) >>> FRAC;
            if (p > 64'sd2147483647) begin p = 64'sd2147483647; st = 1'b1; end
            else if (p < -64'sd2147483648) begin p = -64'sd2147483648; st = 1'b1; end
            acc = acc + p;
            if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; st = 1'b1; end
            else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; st = 1'b1; end
        end
        s    = acc[31:0];
        fire = (acc >= longint'(thr));
    endtask

    task automatic fill(input int xv, input int wv, input int t);
        for (int i = 0; i < N_IN; i++) begin
            x_v[i] = xv;
            w_v[i] = wv;
        end
        thr = t;
    endtask

    task automatic run(input string tag, input int stall);
        logic [31:0] es;
        logic        esat;
        logic        efire;
        logic [31:0] etm;
        int          n;
        model(es, esat, efire);
        for (int i = 0; i < N_IN; i++) begin
            fp_x[i*W +: W] = x_v[i];
            fp_w[i*W +: W] = w_v[i];
        end
        fp_w[N_IN*W +: W] = thr;
        check({tag, ":ready_before"}, 64'(fp_ready), 64'(1'b1));
        etm      = model_cnt + 32'd33;
        fp_start = 1'b1;
        step();
        fp_start = 1'b0;
        for (int i = 0; i < N_IN + 1; i++) fp_w[i*W +: W] = $urandom;
        for (int i = 0; i < N_IN; i++) fp_x[i*W +: W] = $urandom;
        n = 1;
        check({tag, ":ready_busy"}, 64'(fp_ready), 64'(1'b0));
        while (!fp_out_valid && n < 100) begin
            step();
            n++;
        end
        check({tag, ":latency"}, 64'(n), 64'(34));
        check({tag, ":sum"}, 64'(fp_sum), 64'(es));
        check({tag, ":fire"}, 64'(fp_fire), 64'(efire));
        check({tag, ":sat"}, 64'(fp_sat), 64'(esat));
        check({tag, ":tm"}, 64'(fp_tm), 64'(etm));
        if (stall > 0) begin
            fp_out_ready = 1'b0;
            fp_start     = 1'b1;
            for (int k = 0; k < stall; k++) begin
                step();
                check({tag, ":stall_valid"}, 64'(fp_out_valid), 64'(1'b1));
                check({tag, ":stall_ready"}, 64'(fp_ready), 64'(1'b0));
                check({tag, ":stall_sum"}, 64'(fp_sum), 64'(es));
                check({tag, ":stall_tm"}, 64'(fp_tm), 64'(etm));
            end
            fp_start     = 1'b0;
            fp_out_ready = 1'b1;
        end
        step();
        check({tag, ":valid_drop"}, 64'(fp_out_valid), 64'(1'b0));
        check({tag, ":ready_back"}, 64'(fp_ready), 64'(1'b1));
        check({tag, ":sum_held"}, 64'(fp_sum), 64'(es));
        check({tag, ":fire_held"}, 64'(fp_fire), 64'(efire));
        if (stall > 0) begin
            step();
            step();
            check({tag, ":no_queued_req"}, 64'(fp_out_valid), 64'(1'b0));
            check({tag, ":still_idle"}, 64'(fp_ready), 64'(1'b1));
        end
    endtask

    initial begin
        rst          = 1'b1;
        fp_start     = 1'b0;
        fp_out_ready = 1'b1;
        fp_x         = '0;
        fp_w         = '0;
        step();
        step();
        check("reset:ready", 64'(fp_ready), 64'(1'b1));
        check("reset:valid", 64'(fp_out_valid), 64'(1'b0));
        check("reset:sum", 64'(fp_sum), 64'(0));
        check("reset:fire", 64'(fp_fire), 64'(1'b0));
        check("reset:tm", 64'(fp_tm), 64'(0));
        check("reset:sat", 64'(fp_sat), 64'(1'b0));
        rst = 1'b0;
        step();
        step();

        fill(32'h00010000, 32'h00010000, 32'h001F0000);
        run("thr_met", 0);
        check("thr_met:sum_const", 64'(fp_sum), 64'(32'h00200000));
        fill(32'h00010000, 32'h00010000, 32'h00210000);
        run("thr_missed", 0);
        fill(32'h00010000, 32'h00010000, 32'h00200000);
        run("thr_equal", 0);
        check("thr_equal:fire_const", 64'(fp_fire), 64'(1'b1));

        fill(32'h7FFF0000, 32'h7FFF0000, 0);
        run("sat_pos", 0);
        check("sat_pos:sum_const", 64'(fp_sum), 64'(32'h7FFFFFFF));
        fill(32'h80000000, 32'h7FFF0000, 0);
        run("sat_neg", 0);
        check("sat_neg:sum_const", 64'(fp_sum), 64'(32'h80000000));

        fill(0, 32'h12345678, -5);
        run("neg_thr_zero", 0);

        fill(32'h00018000, 32'hFFFE0000, 32'hFFA00000);
        run("backpressure", 5);
        fill(32'h00008000, 32'h00030000, 32'h00300000);
        run("after_bp", 0);

        // Abort mid-accumulation, then confirm no residue leaks into the next result
        fill(32'h7FFF0000, 32'h7FFF0000, 0);
        for (int i = 0; i < N_IN; i++) begin
            fp_x[i*W +: W] = x_v[i];
            fp_w[i*W +: W] = w_v[i];
        end
        fp_start = 1'b1;
        step();
        fp_start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst:ready", 64'(fp_ready), 64'(1'b1));
        check("midrst:valid", 64'(fp_out_valid), 64'(1'b0));
        check("midrst:sat", 64'(fp_sat), 64'(1'b0));
        check("midrst:tm", 64'(fp_tm), 64'(0));
        fill(0, 0, 0);
        x_v[0] = 32'h00020000;
        w_v[0] = 32'h00030000;
        run("after_rst", 0);
        check("after_rst:sum_const", 64'(fp_sum), 64'(32'h00060000));

        // Reset and request together: reset wins, nothing starts
        rst      = 1'b1;
        fp_start = 1'b1;
        step();
        rst      = 1'b0;
        fp_start = 1'b0;
        step();
        step();
        check("rst_start:ready", 64'(fp_ready), 64'(1'b1));
        check("rst_start:valid", 64'(fp_out_valid), 64'(1'b0));

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (r % 2 == 0) begin
                    x_v[i] = int'($urandom_range(0, 32'h0007FFFF)) - 32'sh00040000;
                    w_v[i] = int'($urandom_range(0, 32'h0007FFFF)) - 32'sh00040000;
                end else begin
                    x_v[i] = $urandom;
                    w_v[i] = $urandom;
                end
            end
            thr = int'($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000;
            run($sformatf("rand%0d", r), (r == 3) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
